program_loader: RTL and testbench
=================================

PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 Parameter MAX_WORDS, default 256: largest accepted program length in 16-bit instruction words.
REQ-002 Parameter BASE_ADDR, default 16'h0000: byte address of the first instruction word written to instruction memory.
REQ-003 Clocking: one clock; reset is synchronous and active-high.
REQ-004 Port clk, input, 1: single clock.
REQ-005 Port rst, input, 1: synchronous, active-high reset.
REQ-006 Port start, input, 1: one-cycle request to begin a load; honoured only in IDLE, DONE or ERROR.
REQ-007 Port in_valid, input, 1: in_data holds a valid byte.
REQ-008 Port in_data, input, 8: serial program byte stream.
REQ-009 Port in_ready, output, 1: loader accepts a byte this cycle; a byte transfers when in_valid && in_ready.
REQ-010 Port mem_we, output, 1: one-cycle instruction-memory write strobe.
REQ-011 Port mem_addr, output, 16: byte address for the write, aligned to 2.
REQ-012 Port mem_wdata, output, 16: instruction word to write.
REQ-013 Port cpu_rst, output, 1: holds the CPU in reset while high.
REQ-014 Port done, output, 1: load completed and checksum matched.
REQ-015 Port error, output, 1: load aborted by a length violation or checksum mismatch.

Function
REQ-016 Stream format: LEN_HI, LEN_LO (16-bit word count N, big-endian), then N words as HI byte followed by LO byte, then one CHK byte.
REQ-017 FSM states: IDLE, LEN_HI, LEN_LO, DATA_HI, DATA_LO, CHECK, DONE, ERROR.
REQ-018 Transition on start: IDLE, DONE or ERROR -> LEN_HI; clears done, error, the word counter and the checksum.
REQ-019 in_ready is high only in LEN_HI, LEN_LO, DATA_HI, DATA_LO and CHECK; each state advances only on a transfer.
REQ-020 Transition from LEN_LO: N == 0 -> CHECK; N > MAX_WORDS -> ERROR; otherwise -> DATA_HI.
REQ-021 DATA_LO transfer produces a one-cycle mem_we registered on the next cycle.
  - mem_wdata = {HI, LO}.
  - mem_addr = BASE_ADDR + 2*k, where k is the 0-based word index; the sum wraps modulo 2^16.
REQ-022 After word N-1 the FSM goes to CHECK; otherwise it returns to DATA_HI.
REQ-023 Checksum is the running XOR of every payload byte (length and data bytes, not CHK).
  - CHK equal to the running XOR -> DONE.
  - CHK not equal -> ERROR.
REQ-024 cpu_rst is high in every state except DONE; it deasserts the cycle after DONE is entered.
REQ-025 done = (state == DONE); error = (state == ERROR); both are registered.
REQ-026 start during LEN_HI..CHECK is ignored; a load in progress is never restarted.
REQ-027 An in_valid gap (in_valid low) stalls the FSM indefinitely with no timeout; no output changes during the stall.
REQ-028 Words already written before an ERROR are not rolled back.
REQ-029 mem_we is never high outside the cycle that follows a DATA_LO transfer.

Reset
REQ-030 On rst: state = IDLE; in_ready = 0; mem_we = 0; mem_addr = BASE_ADDR; mem_wdata = 0; cpu_rst = 1; done = 0; error = 0; counter and checksum = 0.
REQ-031 rst mid-load overrides all other inputs and aborts to IDLE within one cycle, with no further writes.

Structure
REQ-032 The FSM state encoding and the header byte count (2) belong in the shared CPU package.
REQ-033 The block is a single module with no sub-modules; the address adder is inline.

Verification
REQ-034 Scenario N=2: start, then bytes 00 02 A1 23 B4 56 CHK=(00^02^A1^23^B4^56).
  - Writes 16'hA123 to address 0000, then 16'hB456 to address 0002.
  - done=1; cpu_rst falls.
REQ-035 Scenario bad checksum: same stream with CHK XOR 01 -> both words written, then error=1 and cpu_rst stays 1.
REQ-036 Scenario N=0: bytes 00 00 00 -> no mem_we; done=1.
REQ-037 Scenario N=MAX_WORDS+1: after LEN_LO -> error=1; in_ready=0; no mem_we.
REQ-038 Scenario rst mid-load: rst asserted after the second data byte -> IDLE, cpu_rst=1, no further writes; a new start then loads correctly.
REQ-039 Scenario in_valid gaps and ignored start: random in_valid gaps plus a start pulse mid-load -> the same writes and result as a gap-free stream.

Source files
------------

// File: rtl/program_loader_pkg.sv
// Shared definitions for the serial program loader: loader FSM encoding,
// stream header size and the instruction-memory write payload.
package program_loader_pkg;

    localparam int unsigned BYTE_W    = 8;
    localparam int unsigned WORD_W    = 16;
    localparam int unsigned ADDR_W    = 16;
    // Length header is LEN_HI, LEN_LO
    localparam int unsigned HDR_BYTES = 2;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LEN_HI  = 3'd1,
        ST_LEN_LO  = 3'd2,
        ST_DATA_HI = 3'd3,
        ST_DATA_LO = 3'd4,
        ST_CHECK   = 3'd5,
        ST_DONE    = 3'd6,
        ST_ERROR   = 3'd7
    } state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [WORD_W-1:0] data;
    } mem_wr_t;

    // States in which the loader consumes a stream byte
    function automatic logic accepts_byte(input state_t s);
        return s inside {ST_LEN_HI, ST_LEN_LO, ST_DATA_HI, ST_DATA_LO, ST_CHECK};
    endfunction

endpackage

// File: rtl/program_loader.sv
// Serial program loader: receives a length-prefixed, XOR-checksummed byte
// stream, writes 16-bit instruction words to memory and releases the CPU
// from reset only after a fully verified load.
module program_loader
    import program_loader_pkg::*;
#(
    parameter int unsigned MAX_WORDS = 256,
    parameter logic [15:0] BASE_ADDR = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    output logic        cpu_rst,
    output logic        done,
    output logic        error
);

    localparam int unsigned LEN_W = HDR_BYTES * BYTE_W;

    state_t             state_q;
    state_t             state_d;
    logic [LEN_W-1:0]   len_q;
    logic [LEN_W-1:0]   word_cnt_q;
    logic [BYTE_W-1:0]  chk_q;
    logic [BYTE_W-1:0]  hi_q;
    mem_wr_t            wr_q;

    logic               xfer;
    logic [LEN_W-1:0]   n_c;
    logic               last_word;
    logic               clear;
    logic               ld_len_hi;
    logic               ld_len_lo;
    logic               ld_hi;
    logic               wr_word;
    logic               chk_upd;

    assign xfer      = in_valid && in_ready;
    assign n_c       = {len_q[LEN_W-1:BYTE_W], in_data};
    assign last_word = (word_cnt_q + LEN_W'(1)) == len_q;
    assign mem_addr  = wr_q.addr;
    assign mem_wdata = wr_q.data;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode and datapath strobes
    always_comb begin
        state_d   = state_q;
        clear     = 1'b0;
        ld_len_hi = 1'b0;
        ld_len_lo = 1'b0;
        ld_hi     = 1'b0;
        wr_word   = 1'b0;
        chk_upd   = 1'b0;
        unique case (state_q)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (start) begin
                    state_d = ST_LEN_HI;
                    clear   = 1'b1;
                end
            end
            ST_LEN_HI: begin
                if (xfer) begin
                    ld_len_hi = 1'b1;
                    chk_upd   = 1'b1;
                    state_d   = ST_LEN_LO;
                end
            end
            ST_LEN_LO: begin
                if (xfer) begin
                    ld_len_lo = 1'b1;
                    chk_upd   = 1'b1;
                    if (n_c == '0) begin
                        state_d = ST_CHECK;
                    end else if (32'(n_c) > 32'(MAX_WORDS)) begin
                        state_d = ST_ERROR;
                    end else begin
                        state_d = ST_DATA_HI;
                    end
                end
            end
            ST_DATA_HI: begin
                if (xfer) begin
                    ld_hi   = 1'b1;
                    chk_upd = 1'b1;
                    state_d = ST_DATA_LO;
                end
            end
            ST_DATA_LO: begin
                if (xfer) begin
                    wr_word = 1'b1;
                    chk_upd = 1'b1;
                    state_d = last_word ? ST_CHECK : ST_DATA_HI;
                end
            end
            ST_CHECK: begin
                if (xfer) begin
                    state_d = (in_data == chk_q) ? ST_DONE : ST_ERROR;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Length, word counter, checksum and high-byte capture
    always_ff @(posedge clk) begin
        if (rst) begin
            len_q      <= '0;
            word_cnt_q <= '0;
            chk_q      <= '0;
            hi_q       <= '0;
        end else begin
            if (clear) begin
                len_q      <= '0;
                word_cnt_q <= '0;
                chk_q      <= '0;
            end
            if (ld_len_hi) begin
                len_q[LEN_W-1:BYTE_W] <= in_data;
            end
            if (ld_len_lo) begin
                len_q[BYTE_W-1:0] <= in_data;
            end
            if (chk_upd) begin
                chk_q <= chk_q ^ in_data;
            end
            if (ld_hi) begin
                hi_q <= in_data;
            end
            if (wr_word) begin
                word_cnt_q <= word_cnt_q + LEN_W'(1);
            end
        end
    end

    // Memory write port; address wraps modulo 2^16 from BASE_ADDR
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_we    <= 1'b0;
            wr_q.addr <= BASE_ADDR;
            wr_q.data <= '0;
        end else begin
            mem_we <= wr_word;
            if (wr_word) begin
                wr_q.addr <= BASE_ADDR + ADDR_W'(word_cnt_q << 1);
                wr_q.data <= {hi_q, in_data};
            end
        end
    end

    // Status outputs registered from the next state so they track the FSM
    always_ff @(posedge clk) begin
        if (rst) begin
            in_ready <= 1'b0;
            cpu_rst  <= 1'b1;
            done     <= 1'b0;
            error    <= 1'b0;
        end else begin
            in_ready <= accepts_byte(state_d);
            cpu_rst  <= (state_d != ST_DONE);
            done     <= (state_d == ST_DONE);
            error    <= (state_d == ST_ERROR);
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Randomized self-checking bench for program_loader against a stream-level
// reference model (expected writes and final status derived from the bytes).
module tb_program_loader;

    localparam int unsigned MAXW = 16;
    localparam logic [15:0] BASE = 16'h0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        cpu_rst;
    logic        done;
    logic        error;

    int checks   = 0;
    int failures = 0;

    logic [31:0] wr_log[$];
    logic [7:0]  stream[$];
    logic [31:0] exp_wr[$];
    logic        exp_done;
    logic        exp_err;
    int          exp_bytes;

    program_loader #(.MAX_WORDS(MAXW), .BASE_ADDR(BASE)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .cpu_rst   (cpu_rst),
        .done      (done),
        .error     (error)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Log every memory write and hold the CPU-reset / done relationship
    always @(negedge clk) begin
        if (mem_we) wr_log.push_back({mem_addr, mem_wdata});
        check("cpu_rst_vs_done", 32'(cpu_rst), 32'(!done));
    end

    // Reference model: build a stream of n words and its expected outcome
    task automatic build(input int n, input bit bad, input bit fixed);
        logic [7:0]  x;
        logic [15:0] w;
        stream.delete();
        exp_wr.delete();
        stream.push_back(8'(n >> 8));
        stream.push_back(8'(n));
        if (n > int'(MAXW)) begin
            exp_done  = 1'b0;
            exp_err   = 1'b1;
            exp_bytes = 2;
            return;
        end
        for (int k = 0; k < n; k++) begin
            if (fixed) w = (k == 0) ? 16'hA123 : 16'hB456;
            else       w = 16'($urandom);
            stream.push_back(w[15:8]);
            stream.push_back(w[7:0]);
            exp_wr.push_back({16'(int'(BASE) + 2 * k), w});
        end
        x = 8'h00;
        foreach (stream[i]) x ^= stream[i];
        if (bad) x ^= 8'(1 << $urandom_range(0, 7));
        stream.push_back(x);
        exp_done  = !bad;
        exp_err   = bad;
        exp_bytes = stream.size();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gaps);
        int guard = 0;
        if (gaps) begin
            repeat ($urandom_range(0, 3)) begin
                in_valid = 1'b0;
                @(negedge clk);
            end
        end
        in_valid = 1'b1;
        in_data  = b;
        while (!in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 50) check("ready_timeout", 32'(0), 32'(1));
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic compare_result(input string tag);
        check({tag, "_nwr"}, 32'(wr_log.size()), 32'(exp_wr.size()));
        for (int i = 0; i < exp_wr.size() && i < wr_log.size(); i++)
            check({tag, "_wr"}, wr_log[i], exp_wr[i]);
        check({tag, "_done"}, 32'(done), 32'(exp_done));
        check({tag, "_error"}, 32'(error), 32'(exp_err));
        check({tag, "_ready"}, 32'(in_ready), 32'(0));
    endtask

    task automatic run(input string tag, input bit gaps, input bit midstart);
        wr_log.delete();
        pulse_start();
        for (int i = 0; i < exp_bytes; i++) begin
            if (midstart && i == 3) begin
                in_valid = 1'b0;
                pulse_start();
            end
            send_byte(stream[i], gaps);
        end
        repeat (3) @(negedge clk);
        compare_result(tag);
    endtask

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (2) @(negedge clk);
        check("rst_ready", 32'(in_ready), 32'(0));
        check("rst_we", 32'(mem_we), 32'(0));
        check("rst_addr", 32'(mem_addr), 32'(BASE));
        check("rst_wdata", 32'(mem_wdata), 32'(0));
        check("rst_cpu_rst", 32'(cpu_rst), 32'(1));
        check("rst_done", 32'(done), 32'(0));
        check("rst_error", 32'(error), 32'(0));
        rst = 1'b0;
        @(negedge clk);

        build(2, 1'b0, 1'b1);
        check("n2_chk_byte", 32'(stream[6]), 32'(8'h00 ^ 8'h02 ^ 8'hA1 ^ 8'h23 ^ 8'hB4 ^ 8'h56));
        run("n2", 1'b0, 1'b0);

        build(2, 1'b1, 1'b1);
        stream[6] = 8'h00 ^ 8'h02 ^ 8'hA1 ^ 8'h23 ^ 8'hB4 ^ 8'h56 ^ 8'h01;
        run("badchk", 1'b0, 1'b0);
        check("badchk_cpu_rst", 32'(cpu_rst), 32'(1));

        build(0, 1'b0, 1'b0);
        run("n0", 1'b0, 1'b0);

        build(int'(MAXW) + 1, 1'b0, 1'b0);
        run("nmax1", 1'b0, 1'b0);

        build(int'(MAXW), 1'b0, 1'b0);
        run("nmax", 1'b0, 1'b0);

        // Reset right after the second data byte of a two-word load
        build(2, 1'b0, 1'b1);
        wr_log.delete();
        pulse_start();
        for (int i = 0; i < 4; i++) send_byte(stream[i], 1'b0);
        rst      = 1'b1;
        in_valid = 1'b1;
        in_data  = stream[4];
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        in_valid = 1'b0;
        check("midrst_nwr", 32'(wr_log.size()), 32'(1));
        if (wr_log.size() > 0) check("midrst_wr0", wr_log[0], {BASE, 16'hA123});
        check("midrst_ready", 32'(in_ready), 32'(0));
        check("midrst_cpu_rst", 32'(cpu_rst), 32'(1));
        check("midrst_done", 32'(done), 32'(0));
        check("midrst_error", 32'(error), 32'(0));
        run("after_rst", 1'b0, 1'b0);

        for (int it = 0; it < 12; it++) begin
            int r;
            int n;
            r = $urandom_range(0, 9);
            if (r == 0)      n = 0;
            else if (r == 1) n = int'(MAXW) + 1 + $urandom_range(0, 200);
            else             n = $urandom_range(1, MAXW);
            build(n, ($urandom_range(0, 3) == 0), 1'b0);
            run("rand", 1'b1, 1'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
